program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 216 +++++++++++++++++++++
 tb/tb_program_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: receives a program image over a UART byte stream and writes
// it word by word into instruction memory while holding the core in reset.
// Stream format: 0x99 sync byte, 32-bit little-endian word count, then the
// words (little-endian). A status byte (0xAA ok / 0xEE error) is reported
// through a valid/ready handshake toward the UART transmitter.
// Optional feature macro: LOADER_CHECKSUM_EN -- a trailing 32-bit
// little-endian wraparound sum of all words is compared before releasing the core.
module program_loader #(
    parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic        core_rstn,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_ready
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIZE,
        ST_DATA,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'h99;
    localparam logic [7:0] OK_BYTE   = 8'hAA;
    localparam logic [7:0] ERR_BYTE  = 8'hEE;

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] count_q, count_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_adr_q, mem_adr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        core_rstn_q, core_rstn_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    logic [31:0] assembled;
    logic        go_done;
    logic        go_error;

    // State register and all registered outputs; everything clears on reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= 2'd0;
            shift_q     <= 32'd0;
            count_q     <= 32'd0;
            word_idx_q  <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= 32'd0;
            mem_wdata_q <= 32'd0;
            core_rstn_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            core_rstn_q <= core_rstn_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Next-state logic: byte assembly, word writes, status handshake.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned (which would infer a latch).
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        mem_we_d    = 1'b0;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        core_rstn_d = core_rstn_q;
        tx_valid_d  = tx_valid_q;
        tx_byte_d   = tx_byte_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        go_done     = 1'b0;
        go_error    = 1'b0;
        // Little-endian: each new byte enters at the top, so after four
        // bytes the first one received sits in bits [7:0].
        assembled   = {rx_byte, shift_q[31:8]};

        // Status byte retires once the transmitter has taken it.
        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_d    = ST_SIZE;
                    byte_cnt_d = 2'd0;
                end
            end
            ST_SIZE: begin
                if (rx_valid) begin
                    shift_d    = assembled;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        count_d    = assembled;
                        word_idx_d = 32'd0;
                        if (assembled == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CHECK;
`else
                            go_done = 1'b1;
`endif
                        end else if (assembled > MAX_WORDS) begin
                            go_error = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    shift_d    = assembled;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_adr_d   = BASE_ADR + (word_idx_q << 2);
                        mem_wdata_d = assembled;
                        word_idx_d  = word_idx_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_d       = sum_q + assembled;
`endif
                        if (word_idx_q == count_q - 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CHECK;
`else
                            go_done = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (rx_valid) begin
                    shift_d    = assembled;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        go_done  = (assembled == sum_q);
                        go_error = (assembled != sum_q);
                    end
                end
            end
`endif
            ST_DONE: begin
                // Release the core one cycle after DONE is entered.
                core_rstn_d = 1'b1;
            end
            ST_ERROR: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_done) begin
            state_d    = ST_DONE;
            tx_valid_d = 1'b1;
            tx_byte_d  = OK_BYTE;
        end else if (go_error) begin
            state_d    = ST_ERROR;
            tx_valid_d = 1'b1;
            tx_byte_d  = ERR_BYTE;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_rstn = core_rstn_q;
    assign tx_valid  = tx_valid_q;
    assign tx_byte   = tx_byte_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected memory writes
// and status bytes into queues; a monitor pops and compares on every observed
// write strobe and every accepted status byte. Checksum tests are selected by
// LOADER_CHECKSUM_EN, matching the RTL build.
module tb_program_loader;

    localparam logic [31:0] TB_BASE = 32'h0000_0000;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rstn;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        core_rstn;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready;

    int checks   = 0;
    int failures = 0;

    wr_t         wq[$];
    logic [7:0]  tq[$];
    logic [31:0] words[$];

    program_loader #(
        .BASE_ADR (TB_BASE),
        .MAX_WORDS(16384)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .mem_we   (mem_we),
        .mem_adr  (mem_adr),
        .mem_wdata(mem_wdata),
        .core_rstn(core_rstn),
        .tx_valid (tx_valid),
        .tx_byte  (tx_byte),
        .tx_ready (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rstn && mem_we) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual_adr=0x%08h actual_data=0x%08h expected=none",
                         mem_adr, mem_wdata);
            end else begin
                wr_t e;
                e = wq.pop_front();
                check("wr_adr", mem_adr, e.adr);
                check("wr_data", mem_wdata, e.data);
            end
        end
        if (rstn && tx_valid && tx_ready) begin
            if (tq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tx actual=0x%02h expected=none", tx_byte);
            end else begin
                logic [7:0] t;
                t = tq.pop_front();
                check("tx_byte", {24'd0, tx_byte}, {24'd0, t});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tick();
        rx_valid = 1'b1;
        rx_byte  = b;
    endtask

    task automatic quiet();
        tick();
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[7:0]);
        send(w[15:8]);
        send(w[23:16]);
        send(w[31:24]);
    endtask

    // Sends a complete load of the global 'words' queue; the checksum (when
    // enabled) is the true sum plus sum_delta so a bad checksum can be forced.
    task automatic load(input logic [31:0] sum_delta);
        logic [31:0] sum;
        sum = 32'd0;
        send(8'h99);
        send_word(32'(words.size()));
        foreach (words[i]) begin
            wr_t e;
            e.adr  = TB_BASE + 32'(4 * i);
            e.data = words[i];
            wq.push_back(e);
            send_word(words[i]);
            sum = sum + words[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(sum + sum_delta);
`else
        if (sum_delta != 32'd0) $display("note: checksum delta ignored without checksum build");
`endif
        quiet();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
        check({tag, "_mem_adr"},   mem_adr,            32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,          32'd0);
        check({tag, "_core_rstn"}, {31'd0, core_rstn}, 32'd0);
        check({tag, "_tx_valid"},  {31'd0, tx_valid},  32'd0);
        check({tag, "_tx_byte"},   {24'd0, tx_byte},   32'd0);
    endtask

    task automatic do_reset(input string tag);
        tick();
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tx_ready = 1'b1;
        #2;
        check_reset_vals(tag);
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Lets pending outputs drain, then requires every expectation consumed.
    task automatic drain(input string tag, input int cycles);
        repeat (cycles) tick();
        check({tag, "_writes_pending"}, 32'(wq.size()), 32'd0);
        check({tag, "_tx_pending"},     32'(tq.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tx_ready = 1'b1;
        do_reset("reset");

        // Two-word program, status 0xAA, core released.
        begin
            wr_t e;
            e.adr = 32'h0; e.data = 32'h0010_0513; wq.push_back(e);
            e.adr = 32'h4; e.data = 32'h0000_006F; wq.push_back(e);
        end
        tq.push_back(8'hAA);
        send(8'h99);
        send(8'h02); send(8'h00); send(8'h00); send(8'h00);
        send(8'h13); send(8'h05); send(8'h10); send(8'h00);
        send(8'h6F); send(8'h00); send(8'h00); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h0010_0513 + 32'h0000_006F);
`endif
        quiet();
        drain("two_word", 6);
        check("two_word_core_rstn", {31'd0, core_rstn}, 32'd1);
        check("two_word_tx_valid",  {31'd0, tx_valid},  32'd0);
        check("hold_mem_adr",       mem_adr,            32'h0000_0004);
        check("hold_mem_wdata",     mem_wdata,          32'h0000_006F);
        // Terminal: a fresh load attempt must be ignored.
        send(8'h99); send_word(32'd1); send_word(32'h1234_5678); quiet();
        drain("done_terminal", 4);
        check("done_terminal_core_rstn", {31'd0, core_rstn}, 32'd1);

        // Leading junk byte ignored; single word lands at the base address.
        do_reset("reset2");
        send(8'h55);
        words = {32'hEFBE_ADDE};
        tq.push_back(8'hAA);
        load(32'd0);
        drain("junk_prefix", 6);
        check("junk_prefix_core_rstn", {31'd0, core_rstn}, 32'd1);

        // Oversized count: error status, no writes, core stays in reset.
        do_reset("reset3");
        tq.push_back(8'hEE);
        send(8'h99);
        send(8'h01); send(8'h40); send(8'h00); send(8'h00);
        send_word(32'hCAFE_F00D);
        quiet();
        drain("oversize", 6);
        check("oversize_core_rstn", {31'd0, core_rstn}, 32'd0);

        // Zero-word program goes straight to success.
        do_reset("reset4");
        words = {};
        tq.push_back(8'hAA);
        load(32'd0);
        drain("zero_words", 6);
        check("zero_words_core_rstn", {31'd0, core_rstn}, 32'd1);

        // Reset mid-load after the 2nd of 4 words.
        do_reset("reset5");
        begin
            wr_t e;
            e.adr = 32'h0; e.data = 32'h1111_1111; wq.push_back(e);
            e.adr = 32'h4; e.data = 32'h2222_2222; wq.push_back(e);
        end
        send(8'h99);
        send_word(32'd4);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        quiet();
        tick();
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_reset_vals("midload");
        tick();
        tick();
        rstn = 1'b1;
        check_reset_vals("midload_after");
        drain("midload", 2);
        words = {32'h0000_0013};
        tq.push_back(8'hAA);
        load(32'd0);
        drain("reload", 6);
        check("reload_core_rstn", {31'd0, core_rstn}, 32'd1);

        // Transmitter back-pressure: status held 10 cycles, drops after ready.
        do_reset("reset6");
        tx_ready = 1'b0;
        words = {32'h0000_0001};
        load(32'd0);
        begin
            int budget;
            budget = 0;
            while (!tx_valid && budget < 20) begin
                tick();
                budget++;
            end
        end
        check("bp_tx_valid_rise", {31'd0, tx_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_tx_valid_hold", {31'd0, tx_valid}, 32'd1);
            check("bp_tx_byte_hold",  {24'd0, tx_byte},  32'h0000_00AA);
        end
        tq.push_back(8'hAA);
        tick();
        tx_ready = 1'b1;
        @(negedge clk);
        check("bp_tx_valid_ready_cycle", {31'd0, tx_valid}, 32'd1);
        @(negedge clk);
        check("bp_tx_valid_drop", {31'd0, tx_valid}, 32'd0);
        drain("backpressure", 2);

`ifdef LOADER_CHECKSUM_EN
        // Correct checksum 3 for words 1 and 2.
        do_reset("reset7");
        words = {32'd1, 32'd2};
        tq.push_back(8'hAA);
        load(32'd0);
        drain("sum_ok", 6);
        check("sum_ok_core_rstn", {31'd0, core_rstn}, 32'd1);
        // Wrong checksum 4.
        do_reset("reset8");
        words = {32'd1, 32'd2};
        tq.push_back(8'hEE);
        load(32'd1);
        drain("sum_bad", 6);
        check("sum_bad_core_rstn", {31'd0, core_rstn}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
